// File: rtl/serial_adder_pkg.sv
// Shared FSM encodings and default width for the bit-serial adder.
// Imported by serial_adder_ctrl; holds no logic.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell (combinational datapath).
// Ports: a, b, c_in -> s (sum bit), c_out (carry out).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder reused LSB-first, one bit per cycle.
// Ports: clk, rst_n, start, a_in, b_in, c_in -> busy, done, sum, c_out.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_nxt;
  logic             last;

  full_adder u_full_adder (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // Result fills from the MSB so the final bit lands it in place.
  assign res_nxt = {fa_s, res_sh[WIDTH-1:1]};
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum   <= res_nxt;
            c_out <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller that sequences one shared full_adder cell across the bits of two operands. It adds one bit per cycle, LSB first, and holds the carry in a register between cycles. Operands are loaded with a start/busy/done handshake. The block is the first clocked wrapper around the full_adder datapath and is used where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-counter width; derived, do not override.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request to begin an addition; sampled only in IDLE.
a_in  input  WIDTH  operand A; captured on the accepted start edge.
b_in  input  WIDTH  operand B; captured on the accepted start edge.
c_in  input  1  initial carry; captured on the accepted start edge.
busy  output  1  high while an addition is in progress (state RUN).
done  output  1  one-cycle pulse when sum and c_out become valid.
sum  output  WIDTH  result; registered, held until the next result.
c_out  output  1  final carry; registered, held until the next result.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, c_out=0. Operand shift registers, carry register and bit counter are all cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge:
  - load a_sh<=a_in, b_sh<=b_in, carry<=c_in, cnt<=0;
  - go to RUN.
  - Otherwise remain in IDLE.
- RUN (busy=1): one full_adder instance is driven combinationally with a=a_sh[0], b=b_sh[0], c_in=carry. Each edge:
  - a_sh and b_sh shift right by 1;
  - res_sh shifts right with the adder s output entering at the MSB;
  - carry<=adder c_out;
  - cnt<=cnt+1.
- RUN exit: on the edge where cnt==WIDTH-1:
  - sum<=final res_sh value, including the current s bit;
  - c_out<=adder c_out;
  - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0. Return unconditionally to IDLE; start is ignored in this cycle.
- Latency: start accepted at edge k gives busy=1 from edge k to edge k+WIDTH. sum and c_out update at edge k+WIDTH, and done is high between edges k+WIDTH and k+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- start during RUN or DONE is ignored: no queuing, no restart, no error flag.
- a_in, b_in and c_in may change freely after the accepted start edge without affecting the result.
- sum and c_out keep the previous result during a new RUN; only the completing edge updates them.
- Arithmetic: {c_out,sum} = a_in + b_in + c_in modulo 2^(WIDTH+1), unsigned; overflow appears only in c_out.
- Reset mid-RUN: the operation is abandoned and all outputs return to reset values immediately; no done pulse is produced.
- Illegal or unused state encodings go to IDLE.

Decomposition:
- Shared package/header serial_adder_pkg holds the state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH constant.
- Natural sub-module: the existing full_adder, instantiated once (u_full_adder) for the per-bit add. Everything else lives in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a_in=8'h5A, b_in=8'h3C, c_in=0, pulse start -> busy for 8 cycles, done pulse at cycle 8, sum=8'h96, c_out=0.
- a_in=8'hFF, b_in=8'h01, c_in=0 -> sum=8'h00, c_out=1; then a_in=b_in=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
- Start a_in=8'h12, b_in=8'h34; re-pulse start with a_in=8'hAA at cycles 3 and 8 (DONE) -> single done pulse, sum=8'h46; a later start is accepted normally.
- Change a_in and b_in every cycle during RUN after start with 8'h0F+8'hF0, c_in=1 -> sum=8'h00, c_out=1; the changing inputs have no effect.
- Assert rst_n=0 at cycle 4 of RUN -> busy=0, done=0, sum=0, c_out=0 immediately; after release, a fresh 8'h01+8'h01 gives sum=8'h02 and no spurious done beforehand.
- Exhaustive sweep with WIDTH=4: all 512 (a,b,c_in) combinations -> {c_out,sum} equals a+b+c_in each time, and done spacing is WIDTH+2 for back-to-back starts.
